// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder controller: feeds an external 1-bit full adder cell
// LSB-first over WIDTH cycles and collects sum/carry-out behind valid/ready handshakes.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_x1,
    output logic             fa_x2,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            carry_q   <= carry_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (bit_cnt_q == LAST_BIT) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The cell only sees live operands while RUN; it is held at zero otherwise.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        fa_x1     = 1'b0;
        fa_x2     = 1'b0;
        fa_cin    = 1'b0;
        if (state_q == RUN) begin
            fa_x1  = a_sh_q[0];
            fa_x2  = b_sh_q[0];
            fa_cin = carry_q;
        end
    end

    always_comb begin
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    carry_d   = cin;
                    bit_cnt_d = '0;
                    sum_d     = '0;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so the LSB lands in place after WIDTH shifts.
                sum_d     = {fa_s, sum_q[WIDTH-1:1]};
                carry_d   = fa_cout;
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) cout_d = fa_cout;
            end
            default: ;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
